vector_port_arbiter: RTL and testbench



---
 rtl/vector_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vector_port_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port vector storage block.
// Each requester holds one latched operation; grants alternate when both are pending.
module vector_port_arbiter #(
  parameter  int unsigned DATA_WIDTH  = 20,
  parameter  int unsigned DATA_COUNT  = 64,
  localparam int unsigned INDEX_WIDTH = $clog2(DATA_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_get,
  input  logic                   req0_insert,
  input  logic [INDEX_WIDTH-1:0] req0_index,
  input  logic [DATA_WIDTH-1:0]  req0_data_in,
  output logic [DATA_WIDTH-1:0]  req0_data_out,
  output logic                   req0_ready,
  input  logic                   req1_get,
  input  logic                   req1_insert,
  input  logic [INDEX_WIDTH-1:0] req1_index,
  input  logic [DATA_WIDTH-1:0]  req1_data_in,
  output logic [DATA_WIDTH-1:0]  req1_data_out,
  output logic                   req1_ready,
  output logic [INDEX_WIDTH-1:0] vec_index,
  output logic                   vec_get,
  output logic                   vec_insert,
  output logic [DATA_WIDTH-1:0]  vec_data_in,
  input  logic [DATA_WIDTH-1:0]  vec_data_out,
  input  logic                   vec_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             pend_q, pend_d;
  logic [1:0]             is_ins_q, is_ins_d;
  logic [1:0]             ready_q, ready_d;
  logic [INDEX_WIDTH-1:0] idx_q [2];
  logic [INDEX_WIDTH-1:0] idx_d [2];
  logic [DATA_WIDTH-1:0]  dat_q [2];
  logic [DATA_WIDTH-1:0]  dat_d [2];
  logic [DATA_WIDTH-1:0]  dout_q [2];
  logic [DATA_WIDTH-1:0]  dout_d [2];
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic [INDEX_WIDTH-1:0] vec_index_q, vec_index_d;
  logic [DATA_WIDTH-1:0]  vec_data_in_q, vec_data_in_d;
  logic                   vec_get_q, vec_get_d;
  logic                   vec_insert_q, vec_insert_d;
  logic                   busy_q, busy_d;

  logic [1:0]             get_c, ins_c;
  logic [INDEX_WIDTH-1:0] idx_in_c [2];
  logic [DATA_WIDTH-1:0]  dat_in_c [2];
  logic                   pick_c;

  assign get_c       = {req1_get, req0_get};
  assign ins_c       = {req1_insert, req0_insert};
  assign idx_in_c[0] = req0_index;
  assign idx_in_c[1] = req1_index;
  assign dat_in_c[0] = req0_data_in;
  assign dat_in_c[1] = req1_data_in;

  // Sole pending port wins; on a tie the port not served last wins.
  assign pick_c = (&pend_q) ? ~last_q : pend_q[1];

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pend_q        <= '0;
      is_ins_q      <= '0;
      ready_q       <= 2'b11;
      grant_q       <= 1'b0;
      last_q        <= 1'b1;
      vec_index_q   <= '0;
      vec_data_in_q <= '0;
      vec_get_q     <= 1'b0;
      vec_insert_q  <= 1'b0;
      busy_q        <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        idx_q[i]  <= '0;
        dat_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      is_ins_q      <= is_ins_d;
      ready_q       <= ready_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      vec_index_q   <= vec_index_d;
      vec_data_in_q <= vec_data_in_d;
      vec_get_q     <= vec_get_d;
      vec_insert_q  <= vec_insert_d;
      busy_q        <= busy_d;
      for (int i = 0; i < 2; i++) begin
        idx_q[i]  <= idx_d[i];
        dat_q[i]  <= dat_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  // Request acceptance, next state and next output values.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    is_ins_d      = is_ins_q;
    ready_d       = ready_q;
    grant_d       = grant_q;
    last_d        = last_q;
    vec_index_d   = vec_index_q;
    vec_data_in_d = vec_data_in_q;
    vec_get_d     = 1'b0;
    vec_insert_d  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      idx_d[i]  = idx_q[i];
      dat_d[i]  = dat_q[i];
      dout_d[i] = dout_q[i];
    end

    // A ready port never has a pending op, so this cannot collide with completion below.
    for (int i = 0; i < 2; i++) begin
      if (ready_q[i] && (get_c[i] || ins_c[i])) begin
        pend_d[i]   = 1'b1;
        is_ins_d[i] = ins_c[i];
        idx_d[i]    = idx_in_c[i];
        dat_d[i]    = dat_in_c[i];
        ready_d[i]  = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if ((|pend_q) && vec_ready) begin
          grant_d       = pick_c;
          last_d        = pick_c;
          vec_index_d   = idx_q[pick_c];
          vec_data_in_d = dat_q[pick_c];
          vec_insert_d  = is_ins_q[pick_c];
          vec_get_d     = ~is_ins_q[pick_c];
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE:  state_d = ST_SETTLE;
      // Vector ready may still be high from before the strobe; skip one cycle.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (vec_ready) begin
          if (!is_ins_q[grant_q]) begin
            dout_d[grant_q] = vec_data_out;
          end
          pend_d[grant_q]  = 1'b0;
          ready_d[grant_q] = 1'b1;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign req0_data_out = dout_q[0];
  assign req1_data_out = dout_q[1];
  assign req0_ready    = ready_q[0];
  assign req1_ready    = ready_q[1];
  assign vec_index     = vec_index_q;
  assign vec_data_in   = vec_data_in_q;
  assign vec_get       = vec_get_q;
  assign vec_insert    = vec_insert_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vector_port_arbiter.sv
// Bench for vector_port_arbiter: behavioural vector model, per-port result and
// vector-operation scoreboards, a stimulus table and hand-timed corner sequences.
module tb_vector_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_get, req0_insert, req1_get, req1_insert;
  logic [5:0]  req0_index, req1_index;
  logic [19:0] req0_data_in, req1_data_in, req0_data_out, req1_data_out;
  logic        req0_ready, req1_ready;
  logic [5:0]  vec_index;
  logic        vec_get, vec_insert, busy;
  logic [19:0] vec_data_in;

  // Vector model: ready low for lat-1 cycles after a strobe, get data valid on return.
  logic [19:0] mem [64];
  logic [19:0] vdout  = '0;
  logic        vready = 1'b1;
  int          vcnt   = 0;
  int          lat    = 3;
  int          vec_ops = 0;

  int n_chk = 0;
  int n_err = 0;

  typedef struct packed {
    logic        ins;
    logic [5:0]  idx;
    logic [19:0] data;
  } vop_t;

  typedef struct {
    bit          p;
    bit          ins;
    logic [5:0]  idx;
    logic [19:0] data;
    logic [19:0] exp;
    int          lat;
  } vec_t;

  vop_t        vq0[$], vq1[$];
  logic [19:0] eq0[$], eq1[$];
  int          glog[$];
  int          gcnt [2];
  logic [1:0]  prev_rdy = 2'b11;
  int          last_p   = -1;
  vec_t        tbl [9];

  vector_port_arbiter #(.DATA_WIDTH(20), .DATA_COUNT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_get(req0_get), .req0_insert(req0_insert), .req0_index(req0_index),
    .req0_data_in(req0_data_in), .req0_data_out(req0_data_out), .req0_ready(req0_ready),
    .req1_get(req1_get), .req1_insert(req1_insert), .req1_index(req1_index),
    .req1_data_in(req1_data_in), .req1_data_out(req1_data_out), .req1_ready(req1_ready),
    .vec_index(vec_index), .vec_get(vec_get), .vec_insert(vec_insert),
    .vec_data_in(vec_data_in), .vec_data_out(vdout), .vec_ready(vready), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if ((vec_get || vec_insert) && vready) begin
      if (vec_insert) mem[vec_index] <= vec_data_in;
      else            vdout <= mem[vec_index];
      vready  <= 1'b0;
      vcnt    <= lat - 1;
      vec_ops <= vec_ops + 1;
    end else if (!vready) begin
      if (vcnt <= 1) vready <= 1'b1;
      else           vcnt <= vcnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: expected event did not occur", name);
  endtask

  // Monitor: port 0 owns indices 0..31, port 1 owns 32..63, so vec_index names the grantee.
  always @(negedge clk) begin : mon
    bit   p;
    vop_t op;
    logic [19:0] e;
    if (!rst_n) begin
      eq0.delete(); eq1.delete(); vq0.delete(); vq1.delete();
      prev_rdy <= 2'b11;
      last_p   <= -1;
    end else begin
      if (vec_get || vec_insert) begin
        p = vec_index[5];
        chk("vec_ready_at_issue", 32'(vready), 32'(1));
        chk("vec_one_strobe", 32'(vec_get && vec_insert), 32'(0));
        if ((p ? vq1.size() : vq0.size()) == 0) begin
          fail_now("unexpected_vec_op");
        end else begin
          op = p ? vq1.pop_front() : vq0.pop_front();
          chk("vec_op_type", 32'(vec_insert), 32'(op.ins));
          chk("vec_index", 32'(vec_index), 32'(op.idx));
          if (op.ins) chk("vec_data_in", 32'(vec_data_in), 32'(op.data));
        end
        chk("no_repeat_grant", 32'((last_p == int'(p)) && !prev_rdy[~p]), 32'(0));
        glog.push_back(int'(p));
        gcnt[p] <= gcnt[p] + 1;
        last_p  <= int'(p);
      end
      if (req0_ready && !prev_rdy[0]) begin
        if (eq0.size() == 0) fail_now("port0_unexpected_done");
        else begin e = eq0.pop_front(); chk("port0_data_out", 32'(req0_data_out), 32'(e)); end
      end
      if (req1_ready && !prev_rdy[1]) begin
        if (eq1.size() == 0) fail_now("port1_unexpected_done");
        else begin e = eq1.pop_front(); chk("port1_data_out", 32'(req1_data_out), 32'(e)); end
      end
      prev_rdy <= {req1_ready, req0_ready};
    end
  end

  // Drive one strobe on a ready port for one cycle and record its expectations.
  task automatic strobe(input bit p, input bit ins, input logic [5:0] idx,
                        input logic [19:0] data, input logic [19:0] exp);
    vop_t op;
    op = '{ins: ins, idx: idx, data: data};
    if (p) begin
      req1_get = ~ins; req1_insert = ins; req1_index = idx; req1_data_in = data;
      vq1.push_back(op); eq1.push_back(exp);
    end else begin
      req0_get = ~ins; req0_insert = ins; req0_index = idx; req0_data_in = data;
      vq0.push_back(op); eq0.push_back(exp);
    end
    @(negedge clk);
    if (p) begin req1_get = 1'b0; req1_insert = 1'b0; end
    else   begin req0_get = 1'b0; req0_insert = 1'b0; end
  endtask

  task automatic wait_ready(input bit p, output int n);
    n = 0;
    while (!(p ? req1_ready : req0_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now(p ? "port1_ready_timeout" : "port0_ready_timeout");
  endtask

  task automatic do_op(input bit p, input bit ins, input logic [5:0] idx,
                       input logic [19:0] data, input logic [19:0] exp);
    int n;
    wait_ready(p, n);
    strobe(p, ins, idx, data, exp);
  endtask

  task automatic check_reset_vals();
    chk("rst_req0_ready", 32'(req0_ready), 32'(1));
    chk("rst_req1_ready", 32'(req1_ready), 32'(1));
    chk("rst_req0_data_out", 32'(req0_data_out), 32'(0));
    chk("rst_req1_data_out", 32'(req1_data_out), 32'(0));
    chk("rst_vec_strobes", 32'({vec_get, vec_insert}), 32'(0));
    chk("rst_vec_index", 32'(vec_index), 32'(0));
    chk("rst_vec_data_in", 32'(vec_data_in), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
  endtask

  function automatic int grant_at(input int i);
    return (i < glog.size()) ? glog[i] : 9;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin : main
    int n, base, ops0;
    int g0, g1;
    tbl[0] = '{0, 0, 6'd5,  20'h00000, 20'h12345, 2};
    tbl[1] = '{1, 1, 6'd63, 20'hFFFFF, 20'h0ABCD, 4};
    tbl[2] = '{1, 0, 6'd63, 20'h00000, 20'hFFFFF, 2};
    tbl[3] = '{0, 1, 6'd0,  20'h00001, 20'h12345, 5};
    tbl[4] = '{0, 0, 6'd0,  20'h00000, 20'h00001, 3};
    tbl[5] = '{1, 1, 6'd32, 20'h00000, 20'hFFFFF, 2};
    tbl[6] = '{1, 0, 6'd32, 20'h00000, 20'h00000, 6};
    tbl[7] = '{0, 1, 6'd31, 20'hA5A5A, 20'h00001, 2};
    tbl[8] = '{0, 0, 6'd31, 20'h00000, 20'hA5A5A, 3};

    rst_n = 1'b0;
    req0_get = 0; req0_insert = 0; req0_index = '0; req0_data_in = '0;
    req1_get = 0; req1_insert = 0; req1_index = '0; req1_data_in = '0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Single insert, hand-timed against the cycle numbering of the strobe.
    lat = 3;
    strobe(0, 1, 6'd5, 20'h12345, 20'h0);
    chk("ins_c1_ready_low", 32'(req0_ready), 32'(0));
    chk("ins_c1_busy", 32'(busy), 32'(0));
    @(negedge clk);
    chk("ins_c2_vec_insert", 32'(vec_insert), 32'(1));
    chk("ins_c2_vec_get", 32'(vec_get), 32'(0));
    chk("ins_c2_index", 32'(vec_index), 32'(5));
    chk("ins_c2_data", 32'(vec_data_in), 32'(20'h12345));
    chk("ins_c2_busy", 32'(busy), 32'(1));
    @(negedge clk);
    chk("ins_c3_strobe_cleared", 32'(vec_insert), 32'(0));
    chk("ins_c3_index_held", 32'(vec_index), 32'(5));
    repeat (2) @(negedge clk);
    chk("ins_c5_ready_low", 32'(req0_ready), 32'(0));
    @(negedge clk);
    chk("ins_c6_ready_high", 32'(req0_ready), 32'(1));
    chk("ins_c6_data_out", 32'(req0_data_out), 32'(0));

    // Single get on port 1 after preloading through the same port.
    do_op(1, 1, 6'd39, 20'h0ABCD, 20'h0);
    do_op(1, 0, 6'd39, 20'h0, 20'h0ABCD);
    wait_ready(1, n);
    chk("get_port1_data", 32'(req1_data_out), 32'(20'h0ABCD));
    chk("get_port0_untouched", 32'(req0_data_out), 32'(0));

    // Simultaneous pair after a port-1 grant: port 0 first.
    base = glog.size();
    fork
      strobe(0, 1, 6'd6, 20'h22222, 20'h0);
      strobe(1, 0, 6'd39, 20'h0, 20'h0ABCD);
    join
    wait_ready(0, n);
    wait_ready(1, n);
    chk("pairA_first", 32'(grant_at(base)), 32'(0));
    chk("pairA_second", 32'(grant_at(base + 1)), 32'(1));
    do_op(0, 0, 6'd6, 20'h0, 20'h22222);
    wait_ready(0, n);
    // Simultaneous pair after a port-0 grant: port 1 first.
    base = glog.size();
    fork
      strobe(0, 0, 6'd5, 20'h0, 20'h12345);
      strobe(1, 1, 6'd33, 20'h33333, 20'h0ABCD);
    join
    wait_ready(0, n);
    wait_ready(1, n);
    chk("pairB_first", 32'(grant_at(base)), 32'(1));
    chk("pairB_second", 32'(grant_at(base + 1)), 32'(0));

    // Table: one op at a time with varying vector latency; completion is lat+3 cycles after the strobe.
    for (int i = 0; i < 9; i++) begin
      lat = tbl[i].lat;
      do_op(tbl[i].p, tbl[i].ins, tbl[i].idx, tbl[i].data, tbl[i].exp);
      wait_ready(tbl[i].p, n);
      chk("tbl_latency", 32'(n + 1), 32'(tbl[i].lat + 3));
    end

    // Saturation: both ports re-strobe the cycle their ready returns.
    lat = 2;
    g0 = gcnt[0];
    g1 = gcnt[1];
    fork
      begin : sat0
        logic [19:0] cur, d;
        cur = 20'hA5A5A;
        d   = '0;
        for (int k = 0; k < 10; k++) begin
          if (k % 2 == 0) begin
            d = 20'($urandom);
            do_op(0, 1, 6'(16 + k / 2), d, cur);
          end else begin
            do_op(0, 0, 6'(16 + k / 2), 20'h0, d);
            cur = d;
          end
        end
      end
      begin : sat1
        logic [19:0] cur, d;
        cur = 20'h00000;
        d   = '0;
        for (int k = 0; k < 10; k++) begin
          if (k % 2 == 0) begin
            d = 20'($urandom);
            do_op(1, 1, 6'(48 + k / 2), d, cur);
          end else begin
            do_op(1, 0, 6'(48 + k / 2), 20'h0, d);
            cur = d;
          end
        end
      end
    join
    wait_ready(0, n);
    wait_ready(1, n);
    chk("sat_grants_port0", 32'(gcnt[0] - g0), 32'(10));
    chk("sat_grants_port1", 32'(gcnt[1] - g1), 32'(10));

    // Strobe while not ready is dropped.
    lat  = 3;
    ops0 = vec_ops;
    do_op(0, 0, 6'd5, 20'h0, 20'h12345);
    req0_insert = 1'b1; req0_index = 6'd7; req0_data_in = 20'h77777;
    @(negedge clk);
    req0_insert = 1'b0;
    wait_ready(0, n);
    repeat (4) @(negedge clk);
    chk("ignored_strobe_vec_ops", 32'(vec_ops - ops0), 32'(1));

    // Reset in WAIT with port 1 pending; the vector's in-flight insert still lands.
    lat = 8;
    do_op(0, 1, 6'd10, 20'h5A5A5, 20'h12345);
    strobe(1, 0, 6'd45, 20'h0, 20'h0);
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'(1));
    chk("mid_port1_pending", 32'(req1_ready), 32'(0));
    #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals();
    #2 rst_n = 1'b1;
    lat  = 3;
    ops0 = vec_ops;
    do_op(0, 0, 6'd10, 20'h0, 20'h5A5A5);
    wait_ready(0, n);
    chk("post_reset_vec_ops", 32'(vec_ops - ops0), 32'(1));
    chk("post_reset_data", 32'(req0_data_out), 32'(20'h5A5A5));
    chk("post_reset_port1_idle", 32'(req1_ready), 32'(1));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(eq0.size() + eq1.size() + vq0.size() + vq1.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
